capture_arbiter: RTL and testbench

Shares one capture counter between NREQ requesters that each need a snapshot of the running count. Round-robin arbitration picks one requester, pulses the counter's capture input, waits for its valid, then returns the captured value with a one-hot grant. Sits between the counter instance and its consumers. A timeout protects against a counter that never asserts valid.

---
 rtl/capture_arbiter_if.sv | 13 +
 rtl/capture_arbiter.sv | 76 +++++++
 tb/tb_capture_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_arbiter_if.sv
// capture_arbiter_if: requester/counter/result bundle; slave side is the arbiter
interface capture_arbiter_if #(parameter int NREQ = 4, parameter int WIDTH = 8);
  logic [NREQ-1:0]  req;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_valid;
  logic             capture;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] rdata;
  logic             err;
  logic             busy;
  modport master (output req, cnt_q, cnt_valid, input capture, gnt, rdata, err, busy);
  modport slave  (input req, cnt_q, cnt_valid, output capture, gnt, rdata, err, busy);
endinterface

// File: rtl/capture_arbiter.sv
// capture_arbiter: round-robin share of one capture counter with timeout; CAPTURE_ARBITER_FIXED_PRI_EN makes req[0] top priority
module capture_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input logic             clock,
  input logic             reset,
  capture_arbiter_if.slave bus
);
  localparam int SW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, CAP = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0]       state;
  logic [SW-1:0]    sel, last, pick;
  logic [TW-1:0]    timer;
  logic             to;
  logic [WIDTH-1:0] rdata;
  logic [NREQ-1:0]  rr_req;
`ifdef CAPTURE_ARBITER_FIXED_PRI_EN
  assign rr_req = bus.req & ~NREQ'(1);
`else
  assign rr_req = bus.req;
`endif
  // descending scan so the nearest requester after last is written last and wins
  always_comb begin
    pick = last;
    for (int i = NREQ; i >= 1; i--)
      if (rr_req[(int'(last) + i) % NREQ]) pick = SW'((int'(last) + i) % NREQ);
`ifdef CAPTURE_ARBITER_FIXED_PRI_EN
    if (bus.req[0]) pick = '0;
`endif
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      last  <= SW'(NREQ - 1);
      timer <= '0;
      to    <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          sel   <= pick;
          state <= CAP;
        end
        CAP: begin
          timer <= '0;
          to    <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (bus.cnt_valid) begin
          rdata <= bus.cnt_q;
          state <= DONE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          to    <= 1'b1;
          state <= DONE;
        end else timer <= timer + 1'b1;
        DONE: begin
`ifdef CAPTURE_ARBITER_FIXED_PRI_EN
          if (sel != '0) last <= sel;
`else
          last <= sel;
`endif
          state <= IDLE;
        end
      endcase
    end
  // pulses decode straight from state so reset clears them asynchronously
  assign bus.capture = state == CAP;
  assign bus.gnt     = state == DONE ? NREQ'(1) << sel : '0;
  assign bus.err     = state == DONE && to;
  assign bus.busy    = state != IDLE;
  assign bus.rdata   = rdata;
endmodule

// File: tb/tb_capture_arbiter.sv
// tb_capture_arbiter: scoreboard bench; expected grants queued at stimulus, popped when gnt fires
module tb_capture_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  capture_arbiter_if #(.NREQ(4), .WIDTH(8)) bus();
  capture_arbiter #(.NREQ(4), .WIDTH(8), .TIMEOUT(15)) dut (.clock(clock), .reset(reset), .bus(bus));
  typedef struct packed {logic [3:0] g; logic [7:0] d; logic e;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  logic       resp_en = 1'b1, pend = 1'b0;
  logic [7:0] base = 8'h00, ncap = 8'h00;
  int         dly = 0, wc = 0;
  // counter model: answers the k-th capture with base+k after dly WAIT cycles
  always @(negedge clock) begin
    bus.cnt_valid = pend && resp_en && (wc == dly);
    bus.cnt_q = base + ncap;
    if (pend) begin
      if (wc == dly) begin
        pend = 1'b0;
        ncap = ncap + 8'd1;
      end else wc++;
    end
    if (bus.capture) begin
      pend = 1'b1;
      wc = 0;
    end
  end
  always @(negedge clock)
    if (bus.gnt !== 4'b0000) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_gnt gnt=%b rdata=%h err=%b required no grant", bus.gnt, bus.rdata, bus.err);
      end else begin
        e = sb.pop_front();
        if ({bus.gnt, bus.rdata, bus.err} !== e || $countones(bus.gnt) != 1) begin
          errors++;
          $display("FAIL grant gnt=%b rdata=%h err=%b required gnt=%b rdata=%h err=%b", bus.gnt, bus.rdata, bus.err, e.g, e.d, e.e);
        end
      end
    end
  task automatic do_reset;
    reset = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected count=%0d required 0", sb.size());
    end
    sb.delete();
    resp_en = 1'b1;
    dly = 0;
    pend = 1'b0;
    ncap = 8'h00;
    reset = 1'b0;
  endtask
  task automatic wait_grants(input int n, input int budget);
    int got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clock);
      if (bus.gnt !== 4'b0000) got++;
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL wait_grants got=%0d required=%0d", got, n);
    end
  endtask
  task automatic test_reset;
    bus.req = '0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.capture, bus.gnt, bus.err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_pulses busy=%b capture=%b gnt=%b err=%b required all 0", bus.busy, bus.capture, bus.gnt, bus.err);
    end
    checks++;
    if (bus.rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata got=%h required=00", bus.rdata);
    end
    do_reset();
  endtask
  task automatic test_single;
    do_reset();
    base = 8'h2A;
    bus.req = 4'b0001;
    sb.push_back('{4'b0001, 8'h2A, 1'b0});
    @(negedge clock);
    bus.req = '0;
    checks++;
    if (bus.capture !== 1'b1) begin
      errors++;
      $display("FAIL single_capture_on got=%b required=1", bus.capture);
    end
    @(negedge clock);
    checks++;
    if (bus.capture !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_capture_off capture=%b busy=%b required capture=0 busy=1", bus.capture, bus.busy);
    end
    @(negedge clock);
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++;
      $display("FAIL single_latency gnt=%b required=0001", bus.gnt);
    end
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.rdata !== 8'h2A) begin
      errors++;
      $display("FAIL single_hold busy=%b rdata=%h required busy=0 rdata=2a", bus.busy, bus.rdata);
    end
  endtask
  task automatic test_round_robin;
`ifdef CAPTURE_ARBITER_FIXED_PRI_EN
    logic [3:0] order [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    do_reset();
    base = 8'h40;
    for (int k = 0; k < 5; k++) sb.push_back('{order[k], 8'h40 + 8'(k), 1'b0});
    bus.req = 4'b1111;
    wait_grants(5, 40);
    bus.req = '0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle busy=%b required=0", bus.busy);
    end
  endtask
  task automatic test_timeout;
    int n = 0;
    do_reset();
    base = 8'h55;
    bus.req = 4'b0001;
    sb.push_back('{4'b0001, 8'h55, 1'b0});
    @(negedge clock);
    bus.req = '0;
    wait_grants(1, 10);
    @(negedge clock);
    resp_en = 1'b0;
    bus.req = 4'b0100;
    sb.push_back('{4'b0100, 8'h55, 1'b1});
    do begin
      @(negedge clock);
      n++;
      if (n == 1) bus.req = '0;
    end while (bus.gnt === 4'b0000 && n < 40);
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL timeout_latency cycles=%0d required=17", n);
    end
    resp_en = 1'b1;
  endtask
  task automatic test_timeout_edge;
    int n;
    do_reset();
    base = 8'h60;
    for (int k = 0; k < 2; k++) begin
      dly = 14 + k;
      sb.push_back('{4'b0010, 8'h60, k == 1});
      bus.req = 4'b0010;
      n = 0;
      do begin
        @(negedge clock);
        n++;
        if (n == 1) bus.req = '0;
      end while (bus.gnt === 4'b0000 && n < 40);
      checks++;
      if (n != 17) begin
        errors++;
        $display("FAIL timeout_edge_latency dly=%0d cycles=%0d required=17", dly, n);
      end
      @(negedge clock);
    end
  endtask
  task automatic test_reset_mid;
    do_reset();
    resp_en = 1'b0;
    bus.req = 4'b0001;
    @(negedge clock);
    bus.req = '0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.capture, bus.gnt} !== 6'b0 || bus.rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid busy=%b capture=%b gnt=%b rdata=%h required all 0", bus.busy, bus.capture, bus.gnt, bus.rdata);
    end
    do_reset();
    base = 8'h77;
    bus.req = 4'b0010;
    sb.push_back('{4'b0010, 8'h77, 1'b0});
    @(negedge clock);
    bus.req = '0;
    wait_grants(1, 10);
  endtask
  task automatic test_req_drop;
    do_reset();
    base = 8'h33;
    bus.req = 4'b1000;
    sb.push_back('{4'b1000, 8'h33, 1'b0});
    @(negedge clock);
    bus.req = '0;
    wait_grants(1, 10);
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL req_drop_idle busy=%b gnt=%b required busy=0 gnt=0000", bus.busy, bus.gnt);
    end
  endtask
  task automatic test_priority;
`ifdef CAPTURE_ARBITER_FIXED_PRI_EN
    logic [3:0] order [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    logic [3:0] order [4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
`endif
    do_reset();
    base = 8'h10;
    for (int k = 0; k < 4; k++) sb.push_back('{order[k], 8'h10 + 8'(k), 1'b0});
    bus.req = 4'b1001;
    wait_grants(4, 40);
    bus.req = '0;
    repeat (3) @(negedge clock);
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_req_drop();
    test_priority();
    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
